// File: rtl/sha_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module   : sha_msg_schedule
// Purpose  : SHA-2 message-schedule expander. Loads one padded block as 16
//            serial words, then streams W[0..ROUNDS-1] one word per cycle
//            under valid/ready backpressure. Serves SHA-256 (WORD_W=32,
//            ROUNDS=64) and SHA-512 (WORD_W=64, ROUNDS=80).
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            in_valid   - in_word valid
//            in_ready   - block accepts a word (high only while loading)
//            in_word    - message word, W[0] first
//            out_valid  - out_word holds a schedule word
//            out_ready  - consumer accepts out_word
//            out_word   - registered W[out_idx]
//            out_idx    - schedule index t
//            out_last   - final schedule word of the block
// Revision : 1.0 - initial release
// ============================================================================
module sha_msg_schedule #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [6:0]        out_idx,
  output logic              out_last
);

  // Only the two SHA-2 geometries are meaningful; anything else is rejected
  // at elaboration.
  generate
    if (!((WORD_W == 32 && ROUNDS == 64) || (WORD_W == 64 && ROUNDS == 80))) begin : g_bad_params
      $error("sha_msg_schedule: WORD_W/ROUNDS must be 32/64 or 64/80");
    end
  endgenerate

  // Small-sigma rotate/shift amounts for the selected word width.
  localparam int S0_ROT_A = (WORD_W == 32) ? 7  : 1;
  localparam int S0_ROT_B = (WORD_W == 32) ? 18 : 8;
  localparam int S0_SHR   = (WORD_W == 32) ? 3  : 7;
  localparam int S1_ROT_A = (WORD_W == 32) ? 17 : 19;
  localparam int S1_ROT_B = (WORD_W == 32) ? 19 : 61;
  localparam int S1_SHR   = (WORD_W == 32) ? 10 : 6;

  localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [WORD_W-1:0] r_ring [16];

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return rotr(x, S0_ROT_A) ^ rotr(x, S0_ROT_B) ^ (x >> S0_SHR);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return rotr(x, S1_ROT_A) ^ rotr(x, S1_ROT_B) ^ (x >> S1_SHR);
  endfunction

  // Ring slots relative to the current index t (4-bit wrap gives mod 16):
  // t+1 holds W[t-15] until overwritten by W[t+1], t-1 holds W[t-1],
  // t+10 holds W[t-6], t+2 holds W[t-14].
  logic [3:0]        w_slot_next;
  logic [3:0]        w_slot_m2;
  logic [3:0]        w_slot_m7;
  logic [3:0]        w_slot_m15;
  logic              w_use_recur;
  logic [WORD_W-1:0] w_recur;
  logic [WORD_W-1:0] w_next_word;

  assign w_slot_next = out_idx[3:0] + 4'd1;
  assign w_slot_m2   = out_idx[3:0] + 4'd15;
  assign w_slot_m7   = out_idx[3:0] + 4'd10;
  assign w_slot_m15  = out_idx[3:0] + 4'd2;

  // Next index t+1 >= 16 needs the recurrence; below that the word is
  // still the loaded message word.
  assign w_use_recur = (out_idx >= 7'd15);
  assign w_recur     = sig1(r_ring[w_slot_m2]) + r_ring[w_slot_m7]
                     + sig0(r_ring[w_slot_m15]) + r_ring[w_slot_next];
  assign w_next_word = w_use_recur ? w_recur : r_ring[w_slot_next];

  assign in_ready = (r_state == ST_LOAD);
  assign out_last = out_valid && (out_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_LOAD;
      r_cnt     <= 4'd0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_idx   <= 7'd0;
      for (int i = 0; i < 16; i++) begin
        r_ring[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (in_valid) begin
            r_ring[r_cnt] <= in_word;
            r_cnt         <= r_cnt + 4'd1;  // wraps back to 0 after slot 15
            if (r_cnt == 4'd15) begin
              // Slot 0 was written on the first handshake, so on the last
              // one it is never the slot being written; no bypass needed.
              out_word  <= r_ring[0];
              out_idx   <= 7'd0;
              out_valid <= 1'b1;
              r_state   <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (out_valid && out_ready) begin
            if (out_idx == LAST_IDX) begin
              out_valid <= 1'b0;
              r_state   <= ST_LOAD;
            end else begin
              out_idx  <= out_idx + 7'd1;
              out_word <= w_next_word;
              if (w_use_recur) begin
                r_ring[w_slot_next] <= w_recur;
              end
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/sha_msg_schedule.md
# sha_msg_schedule

Parametrised SHA-2 message-schedule expander. It accepts one 512-bit or 1024-bit padded block as 16 serial words, then streams the full schedule W[0..ROUNDS-1], one word per cycle under backpressure. It applies the small-sigma functions internally. It sits between the block padder and the compression-round datapath, and serves both SHA-256 (32-bit) and SHA-512 (64-bit) modes.

## Interface
- WORD_W, 32, word width; legal values are 32 (SHA-256) or 64 (SHA-512); any other value is an elaboration error.
- ROUNDS, 64, schedule length; must be 64 when WORD_W=32 and 80 when WORD_W=64, else elaboration error.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  block accepts an input word; high exactly in state LOAD.
- in_word  in  WORD_W  message word, big-endian word order, W[0] first.
- out_valid  out  1  out_word holds a valid schedule word.
- out_ready  in  1  consumer accepts out_word.
- out_word  out  WORD_W  W[out_idx], registered.
- out_idx  out  7  schedule index t, 0..ROUNDS-1.
- out_last  out  1  out_valid && out_idx==ROUNDS-1.

## Operation
- Storage: a 16-entry ring of WORD_W registers. The slot index is a 4-bit value that wraps naturally mod 16.
- Small-sigma functions, selected by WORD_W:
  - WORD_W=32: s0 = ROTR7^ROTR18^SHR3; s1 = ROTR17^ROTR19^SHR10.
  - WORD_W=64: s0 = ROTR1^ROTR8^SHR7; s1 = ROTR19^ROTR61^SHR6.
- Recurrence, for t≥16: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^WORD_W; carries beyond WORD_W are discarded.
- State LOAD (the reset state):
  - in_ready=1, out_valid=0.
  - Each in_valid&&in_ready handshake writes in_word to slot cnt and increments cnt (0..15).
  - On the handshake with cnt==15: out_word<=W[0] (the ring's slot 0, bypassing with in_word when it is the word being written), out_idx<=0, out_valid<=1, state→EMIT, cnt<=0.
- State EMIT:
  - in_ready=0; input words are ignored.
  - On out_valid&&out_ready at index t:
    - If t==ROUNDS-1: out_valid<=0, state→LOAD.
    - Else: out_idx<=t+1 and out_word<=W[t+1].
  - Source of W[t+1]:
    - For t+1<16: slot (t+1) mod 16.
    - For t+1≥16: the recurrence using slots (t-1), (t+10), (t+2), (t+1), all mod 16, for W[t-1], W[t-6], W[t-14], W[t-15].
    - The computed word is written into slot (t+1) mod 16 at the same edge.
  - Without a handshake, out_word, out_idx and the ring hold unchanged (AXI-style; the output must not change while stalled).
- Reset values, asynchronous:
  - state=LOAD, cnt=0, out_valid=0, out_word=0, out_idx=0, ring cleared to 0.
  - in_ready reads 1 after reset release; handshakes are not recognised while rst_n=0.
- Reset asserted mid-LOAD or mid-EMIT discards the partial block and any remaining schedule words. Nothing is emitted until 16 new words are loaded.
- No abort or flush input; the only way to terminate a block early is reset.

## Timing
- Input throughput: one word per cycle; a 16-word load takes 16 cycles minimum.
- Latency: the 16th input handshake is at edge N; out_valid=1 with W[0] is visible after edge N (cycle N+1).
- Output throughput: one word per cycle with out_ready held high. EMIT lasts ROUNDS cycles minimum.
- Block period: 16 + ROUNDS cycles minimum (80 for SHA-256, 96 for SHA-512). No overlap of load and emit.
- After the last output handshake (out_last) at edge M, in_ready=1 from cycle M+1.
- Critical path: a three-operand-rotate XOR feeding a 4-input WORD_W adder. Single cycle, not pipelined.

## Test plan
- WORD_W=32, "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1 → out_idx 0..63 contiguous; W16=0x61626380, W17=0x000F0000; all 64 words match the software golden model; out_last only at idx 63.
- WORD_W=64, ROUNDS=80, W0=0x6162638000000000, W15=0x18, others 0 → W16=0x6162638000000000, W17=0x00030000000000C0; all 80 words match the model; out_last at idx 79.
- Backpressure: random out_ready (≈50%) and random in_valid gaps → output sequence identical to the no-stall run; out_word and out_idx stable across every stalled cycle; in_ready=0 throughout EMIT.
- Back-to-back blocks: second block's in_valid held high during EMIT → no word accepted until the cycle after out_last handshake; second block's schedule correct (no ring carry-over).
- Reset mid-EMIT at idx 30, and again mid-LOAD after 7 words → out_valid=0 and in_ready=1 immediately after release. The next full block produces the correct schedule from W[0].
- Wrap/carry: all 16 input words 0xFFFFFFFF → every W[t] for t≥16 equals the model's mod-2^32 result (verifies carry discard and slot wrap at t=16, 32, 48).
